// File: rtl/skey_pkg.sv
// skey_pkg: shared key code width and reader FSM state encoding.
package skey_pkg;
   localparam int KEY_CW = 5;
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ACK      = 2'b01,
      WAIT_CLR = 2'b10
   } state_e;
endpackage

// File: rtl/skey_fifo.sv
// skey_fifo: show-ahead circular FIFO for key codes.
// Ports: clk, rst_n (async active-low), push_i/wdata_i write side,
// pop_i read side, rdata_o head of queue (0 when empty), empty_o, full_o,
// count_o occupancy.
module skey_fifo #(
   parameter int DEPTH = 8,
   parameter int CW    = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [CW-1:0]          wdata_i,
   input  logic                   pop_i,
   output logic [CW-1:0]          rdata_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   logic [CW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [NW-1:0] count_q, count_d;
   logic          do_push, do_pop;
   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      count_d  = count_q + NW'(do_push) - NW'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   always_ff @(posedge clk)
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   assign empty_o = count_q == '0;
   assign full_o  = count_q == NW'(DEPTH);
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/skey_reader.sv
// skey_reader: acknowledges debouncer keys with a one-cycle readn pulse and queues codes.
// Ports: clk, RSTN (async active-low); key_ready/key_out/readn debouncer
// handshake; rd_en/key_code/empty/full/count bus-side FIFO view;
// ovf/clr_ovf sticky discard flag; int_req while codes are pending.
module skey_reader
   import skey_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter bit DROP_ON_FULL = 1'b0,
   parameter int CW           = KEY_CW
) (
   input  logic                   clk,
   input  logic                   RSTN,
   input  logic                   key_ready,
   input  logic [CW-1:0]          key_out,
   output logic                   readn,
   input  logic                   rd_en,
   output logic [CW-1:0]          key_code,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf,
   input  logic                   clr_ovf,
   output logic                   int_req
);
   state_e state_q, state_d;
   logic   readn_q, drop_q, drop_d, ovf_q, ovf_d, push;
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      case (state_q)
         IDLE:
            if (key_ready && (!full || DROP_ON_FULL)) begin
               state_d = ACK;
               // full is latched on ACK entry so a pop during ACK cannot revive a discarded push
               drop_d  = full;
            end
         ACK:      state_d = WAIT_CLR;
         WAIT_CLR: state_d = key_ready ? WAIT_CLR : IDLE;
         default:  state_d = IDLE;
      endcase
      push  = state_q == ACK && !drop_q;
      ovf_d = (state_q == ACK && drop_q) || (ovf_q && !clr_ovf);
   end
   always_ff @(posedge clk or negedge RSTN)
      if (!RSTN) begin
         state_q <= IDLE;
         readn_q <= 1'b1;
         drop_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // registered so readn is low exactly while state_q is ACK
         readn_q <= state_d != ACK;
         drop_q  <= drop_d;
         ovf_q   <= ovf_d;
      end
   skey_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk     (clk),
      .rst_n   (RSTN),
      .push_i  (push),
      .wdata_i (key_out),
      .pop_i   (rd_en),
      .rdata_o (key_code),
      .empty_o (empty),
      .full_o  (full),
      .count_o (count)
   );
   assign readn   = readn_q;
   assign ovf     = ovf_q;
   assign int_req = !empty;
endmodule

// File: tb/tb_skey_reader.sv
// tb_skey_reader: directed bench for skey_reader in backpressure (u0) and drop (u1) modes.
module tb_skey_reader;
   logic clk = 1'b0;
   logic RSTN = 1'b0;
   always #5 clk = ~clk;
   logic [1:0] kr, readn, rd, clr, empty, full, ovf, irq;
   logic [4:0] ko [2];
   logic [4:0] kc [2];
   logic [3:0] cnt [2];
   int acks [2] = '{0, 0};
   int wide = 0;
   logic [1:0] prev_low = 2'b00;
   int pass_n = 0, total_n = 0;
   typedef struct {
      bit         push;
      logic [4:0] code;
      bit         pop;
      int         cnt;
      int         head;
   } vec_t;
   vec_t tbl [20];
   skey_reader #(.DEPTH(8), .DROP_ON_FULL(1'b0), .CW(5)) u0 (
      .clk(clk), .RSTN(RSTN), .key_ready(kr[0]), .key_out(ko[0]), .readn(readn[0]),
      .rd_en(rd[0]), .key_code(kc[0]), .empty(empty[0]), .full(full[0]), .count(cnt[0]),
      .ovf(ovf[0]), .clr_ovf(clr[0]), .int_req(irq[0]));
   skey_reader #(.DEPTH(8), .DROP_ON_FULL(1'b1), .CW(5)) u1 (
      .clk(clk), .RSTN(RSTN), .key_ready(kr[1]), .key_out(ko[1]), .readn(readn[1]),
      .rd_en(rd[1]), .key_code(kc[1]), .empty(empty[1]), .full(full[1]), .count(cnt[1]),
      .ovf(ovf[1]), .clr_ovf(clr[1]), .int_req(irq[1]));
   always @(negedge clk)
      for (int d = 0; d < 2; d++) begin
         if (!readn[d]) acks[d] <= acks[d] + 1;
         if (!readn[d] && prev_low[d]) wide <= wide + 1;
         prev_low[d] <= !readn[d];
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(string n, int act, int exp);
      total_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endtask
   task automatic wait_ack(int d);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         tick();
         seen = !readn[d];
      end
      chk($sformatf("ack_seen_u%0d", d), int'(seen), 1);
   endtask
   task automatic send_key(int d, logic [4:0] code);
      kr[d] = 1'b1;
      ko[d] = code;
      wait_ack(d);
      tick();
      kr[d] = 1'b0;
      tick();
   endtask
   task automatic pop(int d);
      rd[d] = 1'b1;
      tick();
      rd[d] = 1'b0;
   endtask
   initial begin
      int a;
      kr = '0; rd = '0; clr = '0; ko[0] = '0; ko[1] = '0;
      tbl = '{
         '{1'b1, 5'h11, 1'b0, 1, 'h11}, '{1'b1, 5'h12, 1'b0, 2, 'h11},
         '{1'b1, 5'h13, 1'b0, 3, 'h11}, '{1'b1, 5'h14, 1'b1, 3, 'h12},
         '{1'b1, 5'h15, 1'b1, 3, 'h13}, '{1'b1, 5'h16, 1'b1, 3, 'h14},
         '{1'b1, 5'h17, 1'b1, 3, 'h15}, '{1'b1, 5'h18, 1'b1, 3, 'h16},
         '{1'b1, 5'h19, 1'b1, 3, 'h17}, '{1'b1, 5'h1A, 1'b1, 3, 'h18},
         '{1'b1, 5'h1B, 1'b1, 3, 'h19}, '{1'b0, 5'h00, 1'b1, 2, 'h1A},
         '{1'b1, 5'h1C, 1'b1, 2, 'h1B}, '{1'b1, 5'h1D, 1'b0, 3, 'h1B},
         '{1'b1, 5'h1E, 1'b1, 3, 'h1C}, '{1'b0, 5'h00, 1'b1, 2, 'h1D},
         '{1'b0, 5'h00, 1'b1, 1, 'h1E}, '{1'b1, 5'h1F, 1'b1, 1, 'h1F},
         '{1'b0, 5'h00, 1'b1, 0, 'h00}, '{1'b1, 5'h01, 1'b0, 1, 'h01}};
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_readn_u%0d", d), int'(readn[d]), 1);
         chk($sformatf("rst_empty_u%0d", d), int'(empty[d]), 1);
         chk($sformatf("rst_full_u%0d", d), int'(full[d]), 0);
         chk($sformatf("rst_count_u%0d", d), int'(cnt[d]), 0);
         chk($sformatf("rst_code_u%0d", d), int'(kc[d]), 0);
         chk($sformatf("rst_ovf_u%0d", d), int'(ovf[d]), 0);
         chk($sformatf("rst_irq_u%0d", d), int'(irq[d]), 0);
      end
      RSTN = 1'b1;
      tick();
      // single key, debouncer drops ready two cycles after seeing readn low
      a = acks[0];
      kr[0] = 1'b1;
      ko[0] = 5'h0A;
      wait_ack(0);
      tick();
      chk("single_empty", int'(empty[0]), 0);
      chk("single_code", int'(kc[0]), 'h0A);
      chk("single_irq", int'(irq[0]), 1);
      chk("single_readn_back", int'(readn[0]), 1);
      tick();
      kr[0] = 1'b0;
      tick();
      tick();
      chk("single_acks", acks[0] - a, 1);
      pop(0);
      chk("single_pop_empty", int'(empty[0]), 1);
      chk("single_pop_code", int'(kc[0]), 0);
      chk("single_pop_irq", int'(irq[0]), 0);
      // burst fill with backpressure
      for (int i = 1; i <= 8; i++) send_key(0, 5'(i));
      chk("burst_full", int'(full[0]), 1);
      chk("burst_count", int'(cnt[0]), 8);
      a = acks[0];
      kr[0] = 1'b1;
      ko[0] = 5'h09;
      repeat (6) tick();
      chk("burst_hold_readn", int'(readn[0]), 1);
      chk("burst_hold_acks", acks[0] - a, 0);
      chk("burst_head", int'(kc[0]), 1);
      pop(0);
      wait_ack(0);
      tick();
      kr[0] = 1'b0;
      tick();
      chk("burst_refill_count", int'(cnt[0]), 8);
      for (int i = 2; i <= 9; i++) begin
         chk($sformatf("burst_drain_%0d", i), int'(kc[0]), i);
         pop(0);
      end
      chk("burst_drained", int'(empty[0]), 1);
      // overflow with discard
      for (int i = 1; i <= 8; i++) send_key(1, 5'(i));
      chk("ovf_full", int'(full[1]), 1);
      chk("ovf_pre", int'(ovf[1]), 0);
      a = acks[1];
      send_key(1, 5'h09);
      chk("ovf_ninth_acked", acks[1] - a, 1);
      chk("ovf_set", int'(ovf[1]), 1);
      chk("ovf_count", int'(cnt[1]), 8);
      chk("ovf_head", int'(kc[1]), 1);
      repeat (3) tick();
      chk("ovf_sticky", int'(ovf[1]), 1);
      clr[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      chk("ovf_clear", int'(ovf[1]), 0);
      // discard with clr_ovf and a pop in the same ACK cycle
      kr[1] = 1'b1;
      ko[1] = 5'h0A;
      wait_ack(1);
      clr[1] = 1'b1;
      rd[1] = 1'b1;
      tick();
      clr[1] = 1'b0;
      rd[1] = 1'b0;
      kr[1] = 1'b0;
      tick();
      chk("ovf_set_wins", int'(ovf[1]), 1);
      chk("ovf_pop_no_push_count", int'(cnt[1]), 7);
      chk("ovf_pop_no_push_head", int'(kc[1]), 2);
      for (int i = 2; i <= 8; i++) begin
         chk($sformatf("ovf_drain_%0d", i), int'(kc[1]), i);
         pop(1);
      end
      chk("ovf_drained", int'(empty[1]), 1);
      // mixed push/pop table, wraps the pointers twice
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].push) begin
            kr[0] = 1'b1;
            ko[0] = tbl[i].code;
            wait_ack(0);
            rd[0] = tbl[i].pop;
            tick();
            rd[0] = 1'b0;
            kr[0] = 1'b0;
            tick();
         end else if (tbl[i].pop) pop(0);
         chk($sformatf("vec%0d_count", i), int'(cnt[0]), tbl[i].cnt);
         chk($sformatf("vec%0d_head", i), int'(kc[0]), tbl[i].head);
      end
      pop(0);
      chk("vec_end_empty", int'(empty[0]), 1);
      // stuck key_ready
      a = acks[0];
      kr[0] = 1'b1;
      ko[0] = 5'h15;
      repeat (50) tick();
      chk("stuck_acks", acks[0] - a, 1);
      chk("stuck_count", int'(cnt[0]), 1);
      chk("stuck_code", int'(kc[0]), 'h15);
      kr[0] = 1'b0;
      tick();
      tick();
      pop(0);
      chk("stuck_empty", int'(empty[0]), 1);
      // reset during ACK
      send_key(0, 5'h06);
      kr[0] = 1'b1;
      ko[0] = 5'h07;
      wait_ack(0);
      #1 RSTN = 1'b0;
      #1;
      chk("mid_rst_readn", int'(readn[0]), 1);
      chk("mid_rst_count", int'(cnt[0]), 0);
      chk("mid_rst_empty", int'(empty[0]), 1);
      tick();
      tick();
      RSTN = 1'b1;
      a = acks[0];
      wait_ack(0);
      tick();
      kr[0] = 1'b0;
      repeat (4) tick();
      chk("post_rst_acks", acks[0] - a, 1);
      chk("post_rst_count", int'(cnt[0]), 1);
      chk("post_rst_code", int'(kc[0]), 'h07);
      chk("readn_width", wide, 0);
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule

// File: doc/skey_reader.md
Name: skey_reader

Overview:
- Consumer side of the scanned-key handshake from the keypad/switch debouncer.
- Watches the debouncer's key_ready/key_out pair, acknowledges each key by pulsing the active-low readn, and queues the 5-bit key codes in a small FIFO.
- The CPU/IO bus pops codes from the FIFO and gets an interrupt request while codes are pending, so keystrokes are not lost between software polls.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- DROP_ON_FULL, 0, 0 = backpressure (no ack while full); 1 = ack and discard while full, set ovf.
- CW, 5, key code width; matches the debouncer key_out.

Ports:
- clk  in  1  system clock, shared with the debouncer.
- RSTN  in  1  asynchronous active-low reset.
- key_ready  in  1  debouncer has a valid code; held until acknowledged.
- key_out  in  CW  key code, stable while key_ready=1.
- readn  out  1  active-low ack to the debouncer; one-cycle low pulse.
- rd_en  in  1  bus pop strobe; ignored when empty.
- key_code  out  CW  head of FIFO (show-ahead); 0 when empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds DEPTH entries.
- count  out  clog2(DEPTH)+1  number of entries.
- ovf  out  1  sticky: a code was discarded (DROP_ON_FULL=1 only).
- clr_ovf  in  1  clears ovf.
- int_req  out  1  equals !empty.

Behaviour:
- Reset (RSTN low, asynchronous):
  - readn=1, FIFO pointers=0, count=0, empty=1, full=0, ovf=0, key_code=0, FSM=IDLE.
  - A reset mid-handshake abandons it; the pending key stays pending at the debouncer and is acked after release.
- All logic is synchronous to clk. key_ready/key_out are already in the clk domain, so no synchronisers.
- FSM states:
  - IDLE
    - key_ready=1 and (!full or DROP_ON_FULL=1) → ACK.
    - Otherwise stay. With DROP_ON_FULL=0 and full, key_ready is left pending (backpressure).
  - ACK (exactly one cycle)
    - readn=0.
    - key_out is captured on this cycle's closing edge.
    - If !full: push. If full (DROP_ON_FULL=1): discard and set ovf.
    - → WAIT_CLR.
  - WAIT_CLR
    - readn=1; wait for key_ready=0, then → IDLE.
    - Prevents double-capture while the debouncer withdraws ready.
- readn is registered (driven from the FSM state register); never glitches.
- Latency: key_ready rises before edge N → readn low in cycle N..N+1 → code written at edge N+1 → empty falls and int_req rises after edge N+1.
- Minimum spacing between acks is 3 cycles: ACK, at least one WAIT_CLR cycle, IDLE.
- FIFO:
  - Circular, pointers wrap modulo DEPTH; count is the separate occupancy.
  - Pop on rd_en & !empty advances rd_ptr at the edge.
  - key_code shows the new head the next cycle.
- Simultaneous push and pop: both happen and count is unchanged. When full, a pop in the ACK cycle does not enable the push, because the full decision is taken at ACK entry.
- rd_en while empty: no pointer or count change, no error.
- ovf:
  - Set on a discard.
  - clr_ovf clears it.
  - Set and clr_ovf in the same cycle → ovf=1 (set wins).

Decomposition:
- Shared package skey_pkg:
  - key code width constant KEY_CW=5.
  - FSM state encoding IDLE=2'b00, ACK=2'b01, WAIT_CLR=2'b10.
- One sub-module: skey_fifo (parameterised DEPTH/CW, show-ahead, push/pop/count/full/empty). The FSM and ovf logic stay in skey_reader.

Test Plan:
- Reset then single key:
  - Stimulus: key_ready=1, key_out=5'h0A. Debouncer model drops key_ready 2 cycles after readn is seen low.
  - Response: exactly one readn low pulse one cycle wide; empty=0 after 2 edges; key_code=5'h0A; int_req=1.
  - Then rd_en pulse → empty=1, key_code=0.
- Burst fill, DROP_ON_FULL=0:
  - Stimulus: 9 keys 5'h01..5'h09 with DEPTH=8.
  - Response: 8 acks; full=1, count=8; key_ready for 5'h09 stays high with readn=1.
  - Then one pop → ack for 5'h09 follows; FIFO order is 01..09 on drain.
- Overflow, DROP_ON_FULL=1:
  - Stimulus: 9 keys.
  - Response: 9 acks; ninth code discarded; ovf=1 sticky.
  - clr_ovf → ovf=0; clr_ovf asserted in the same cycle as a new discard → ovf stays 1.
- Simultaneous push/pop at count=3: count stays 3; read order preserved; pointer wrap exercised after 20 mixed operations.
- Stuck key_ready:
  - Stimulus: key_ready held high for 50 cycles.
  - Response: only one readn pulse and one FIFO entry.
- Reset mid-operation:
  - Stimulus: RSTN low during the ACK cycle.
  - Response: readn=1 and count=0 immediately (asynchronous). After release with key_ready still high, exactly one new ack.
